// File: rtl/image_conv3x3_stream.sv
// Frame-buffered 3x3 convolution over a valid/ready sample stream, with border renormalisation.
// Optional sharpen kernel for mode 3 is built when IMAGE_CONV_SHARPEN_EN is defined.
module image_conv3x3_stream #(
   parameter int WIDTH    = 20,
   parameter int HEIGHT   = 12,
   parameter int CHANNELS = 3,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   // Handshake: a sample moves on a rising edge where valid && ready are both high;
   // out_data is held constant while out_valid && !out_ready.

   localparam int NPIX  = WIDTH * HEIGHT;
   localparam int NSAMP = NPIX * CHANNELS;
   localparam int IDX_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
   localparam int ROW_W = $clog2(HEIGHT + 1);
   localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int ACC_W = DATA_W + 6;
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << DATA_W) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PROCESS,
      S_STREAM,
      S_DONE
   } state_t;

   state_t             state;
   logic [1:0]         mode_q;
   logic [IDX_W-1:0]   idx;
   logic [ROW_W-1:0]   row;
   logic [COL_W-1:0]   col;

   logic [DATA_W-1:0]  in_mem  [NSAMP];
   logic [DATA_W-1:0]  out_mem [NSAMP];

   logic [DATA_W-1:0]  res     [CHANNELS];
   logic [IDX_W-1:0]   wr_idx  [CHANNELS];

   logic signed [ACC_W-1:0] acc, wsum, quo, wgt, smp;
   logic [IDX_W-1:0]        tap;
   int                      rr, cc;

   function automatic logic signed [ACC_W-1:0] weight(input logic [1:0] m, input int dr,
                                                      input int dc);
      int ar, ac, v;
      ar = (dr < 0) ? -dr : dr;
      ac = (dc < 0) ? -dc : dc;
      case (m)
         2'd0:    v = (2 - ar) * (2 - ac);
         2'd1:    v = 1;
`ifdef IMAGE_CONV_SHARPEN_EN
         2'd3:    v = (ar + ac == 0) ? 5 : ((ar + ac == 1) ? -1 : 0);
`endif
         default: v = (ar + ac == 0) ? 1 : 0;
      endcase
      return ACC_W'(v);
   endfunction

   // One pixel per cycle: every channel of (row, col) is filtered in parallel.
   always_comb begin
      acc  = '0;
      wsum = '0;
      quo  = '0;
      wgt  = '0;
      smp  = '0;
      tap  = '0;
      rr   = 0;
      cc   = 0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         acc  = '0;
         wsum = '0;
         for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
               rr = int'(row) + dr;
               cc = int'(col) + dc;
               if (rr >= 0 && rr < HEIGHT && cc >= 0 && cc < WIDTH) begin
                  tap  = IDX_W'((rr * WIDTH + cc) * CHANNELS + ch);
                  wgt  = weight(mode_q, dr, dc);
                  smp  = ACC_W'({1'b0, in_mem[tap]});
                  acc  = acc + wgt * smp;
                  wsum = wsum + wgt;
               end
            end
         end
         // Signed division truncates toward zero; then clamp into the sample range.
         quo = acc / wsum;
         if (quo < 0)
            res[ch] = '0;
         else if (quo > MAX_V)
            res[ch] = MAX_V[DATA_W-1:0];
         else
            res[ch] = quo[DATA_W-1:0];
         wr_idx[ch] = IDX_W'((int'(row) * WIDTH + int'(col)) * CHANNELS + ch);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         mode_q <= '0;
         idx    <= '0;
         row    <= '0;
         col    <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  idx    <= '0;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  if (idx == IDX_W'(NSAMP - 1)) begin
                     idx   <= '0;
                     row   <= '0;
                     col   <= '0;
                     state <= S_PROCESS;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_PROCESS: begin
               if (col == COL_W'(WIDTH - 1)) begin
                  col <= '0;
                  row <= row + 1'b1;
                  if (row == ROW_W'(HEIGHT - 1)) begin
                     idx   <= '0;
                     state <= S_STREAM;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end
            S_STREAM: begin
               if (out_ready) begin
                  if (idx == IDX_W'(NSAMP - 1)) begin
                     idx   <= '0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Frame memories carry no reset; contents are only meaningful once rewritten.
   always_ff @(posedge clk) begin
      if (!reset && state == S_LOAD && in_valid)
         in_mem[idx] <= in_data;
      if (!reset && state == S_PROCESS)
         for (int ch = 0; ch < CHANNELS; ch++)
            out_mem[wr_idx[ch]] <= res[ch];
   end

   assign in_ready  = (state == S_LOAD);
   assign out_valid = (state == S_STREAM);
   assign busy      = (state != S_IDLE);
   assign out_data  = (state == S_STREAM) ? out_mem[idx] : '0;

endmodule

// File: tb/tb_image_conv3x3_stream.sv
// Bench for image_conv3x3_stream: hand table of pixel values plus randomized frames checked
// against a kernel-table reference model (mode 3 expectation follows IMAGE_CONV_SHARPEN_EN).
module tb_image_conv3x3_stream;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int CH    = 3;
   localparam int DW    = 8;
   localparam int NPIX  = W * H;
   localparam int NSAMP = NPIX * CH;

   localparam int F_UNI  = 0;
   localparam int F_IMP  = 1;
   localparam int F_RND  = 2;
   localparam int F_RAMP = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   logic [DW-1:0] frame [NSAMP];
   logic [DW-1:0] got   [NSAMP];
   logic [DW-1:0] exp_q [$];

   typedef struct {
      int mode;
      int fill;
      int r;
      int c;
      int exp;
   } vec_t;
   vec_t vecs [12];

   image_conv3x3_stream #(
      .WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .DATA_W(DW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   // ---- clock / reset ----
   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---- reference model: in-bounds weighted mean, clamped ----
   function automatic void model(input int m);
      int kern [3][3];
      int acc, ws, q, rr, cc;
      exp_q.delete();
      case (m)
         0: kern = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
         1: kern = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
`ifdef IMAGE_CONV_SHARPEN_EN
         3: kern = '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}};
`endif
         default: kern = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
      endcase
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            for (int ch = 0; ch < CH; ch++) begin
               acc = 0;
               ws  = 0;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++) begin
                     rr = r + i - 1;
                     cc = c + j - 1;
                     if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                        acc += kern[i][j] * int'(frame[(rr * W + cc) * CH + ch]);
                        ws  += kern[i][j];
                     end
                  end
               q = acc / ws;
               if (q < 0) q = 0;
               if (q > 255) q = 255;
               exp_q.push_back(DW'(q));
            end
   endfunction

   task automatic fill(input int kind);
      for (int i = 0; i < NSAMP; i++)
         case (kind)
            F_UNI:   frame[i] = 8'h80;
            F_IMP:   frame[i] = (i / CH == 1 * W + 1) ? 8'hFF : 8'h00;
            F_RND:   frame[i] = DW'($urandom_range(0, 255));
            default: frame[i] = DW'(i * 7);
         endcase
   endtask

   // ---- driver: one full frame with optional input gaps and output stalls ----
   task automatic run_frame(input int m, input int vpct, input int rpct);
      int k, cyc, got_n, wait_c, done_before;
      bit accept, rdy, stalled;
      logic [DW-1:0] held, e;
      model(m);
      done_before = done_cnt;
      start = 1'b1;
      mode  = 2'(m);
      @(posedge clk); #1;
      start = 1'b0;
      mode  = 2'($urandom_range(0, 3));
      check("in_ready_after_start", int'(in_ready), 1);
      check("busy_in_load", int'(busy), 1);
      k = 0;
      cyc = 0;
      while (k < NSAMP && cyc < 2000) begin
         in_valid = ($urandom_range(1, 100) <= vpct);
         in_data  = frame[k];
         accept   = in_valid && in_ready;
         @(posedge clk); #1;
         if (accept) k++;
         cyc++;
      end
      in_valid = 1'b0;
      check("load_complete", k, NSAMP);
      check("in_ready_after_load", int'(in_ready), 0);
      wait_c = 0;
      while (!out_valid && wait_c < 1000) begin
         @(posedge clk); #1;
         wait_c++;
      end
      check("process_cycles", wait_c, NPIX);
      got_n = 0;
      cyc = 0;
      stalled = 0;
      held = '0;
      while (got_n < NSAMP && cyc < 2000) begin
         rdy = ($urandom_range(1, 100) <= rpct);
         out_ready = rdy;
         if (stalled && out_valid) check("stall_hold", int'(out_data), int'(held));
         if (out_valid && rdy) begin
            got[got_n] = out_data;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check($sformatf("out_sample_%0d", got_n), int'(out_data), int'(e));
            got_n++;
            stalled = 0;
         end else if (out_valid) begin
            stalled = 1;
            held = out_data;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      check("output_count", got_n, NSAMP);
      check("done_pulse", int'(done), 1);
      check("out_valid_in_done", int'(out_valid), 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_one_cycle", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
      check("start_in_done_ignored", int'(in_ready), 0);
      check("done_count", done_cnt - done_before, 1);
   endtask

   initial begin
      vecs[0]  = '{0, F_UNI, 0, 0, 8'h80};
      vecs[1]  = '{0, F_UNI, 2, 3, 8'h80};
      vecs[2]  = '{0, F_IMP, 1, 1, 8'h3F};
      vecs[3]  = '{0, F_IMP, 0, 0, 8'h1C};
      vecs[4]  = '{0, F_IMP, 0, 3, 8'h00};
      vecs[5]  = '{1, F_IMP, 1, 1, 28};
      vecs[6]  = '{1, F_IMP, 0, 0, 63};
      vecs[7]  = '{2, F_IMP, 1, 1, 8'hFF};
      vecs[8]  = '{2, F_IMP, 1, 2, 8'h00};
      vecs[9]  = '{3, F_UNI, 1, 2, 8'h80};
      vecs[10] = '{3, F_IMP, 1, 1, 8'hFF};
      vecs[11] = '{3, F_IMP, 0, 1, 8'h00};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_in_ready", int'(in_ready), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data", int'(out_data), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);

      // table: one frame per record, back-to-back in and out
      for (int v = 0; v < 12; v++) begin
         fill(vecs[v].fill);
         run_frame(vecs[v].mode, 100, 100);
         for (int ch = 0; ch < CH; ch++)
            check($sformatf("vec%0d_ch%0d", v, ch),
                  int'(got[(vecs[v].r * W + vecs[v].c) * CH + ch]), vecs[v].exp);
      end

      // identity with gappy input, ramp box with stalled output
      fill(F_RND);
      run_frame(2, 100, 100);
      fill(F_RND);
      run_frame(2, 50, 100);
      fill(F_RAMP);
      run_frame(1, 100, 40);

      // random modes, random gaps on both sides
      for (int n = 0; n < 4; n++) begin
         fill(F_RND);
         run_frame($urandom_range(0, 3), 70, 60);
      end

      // in_valid in IDLE stores nothing; reset mid-LOAD discards the partial frame
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      start = 1'b1;
      mode  = 2'd0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = DW'($urandom_range(0, 255));
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      check("midload_reset_in_ready", int'(in_ready), 0);
      check("midload_reset_busy", int'(busy), 0);
      check("midload_reset_out_valid", int'(out_valid), 0);
      check("midload_reset_done", int'(done), 0);
      fill(F_RND);
      run_frame(0, 80, 80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/image_conv3x3_stream.md
# image_conv3x3_stream

Parametrised 3×3 image convolution engine; successor to the single-kernel, fixed-size blur stage.
- Buffers one full frame of channel-interleaved samples received over a valid/ready stream.
- Filters every pixel with a run-time selectable kernel, renormalising at image borders.
- Returns the filtered frame over a second valid/ready stream.
- Sits between the pixel source (camera/file reader) and downstream image-processing stages.

## Interface
Parameters:
- WIDTH, 20, pixels per row (≥2)
- HEIGHT, 12, rows per frame (≥2)
- CHANNELS, 3, samples per pixel, interleaved channel 0 first (1..4)
- DATA_W, 8, bits per sample

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- mode  in  2  kernel select, latched when start is accepted
- in_valid  in  1  input sample valid
- in_data  in  DATA_W  input sample
- in_ready  out  1  high only in LOAD
- out_valid  out  1  output sample valid
- out_data  out  DATA_W  output sample
- out_ready  in  1  downstream accepts sample
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last output transfer

## Operation
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0; state=IDLE; all counters 0. Frame memories are not cleared.
- States: IDLE → LOAD → PROCESS → STREAM → DONE → IDLE.
- IDLE: start=1 latches mode and goes to LOAD.
- LOAD: a sample is stored on each in_valid && in_ready.
  - Order: row-major, channels interleaved, index (r*WIDTH+c)*CHANNELS+ch.
  - After sample WIDTH*HEIGHT*CHANNELS−1 is accepted, go to PROCESS.
- PROCESS: one pixel per cycle in row-major order, all channels in parallel.
  - Uses the 3×3 neighbourhood centred on (r,c).
  - Taps outside the image are excluded from both the sum and the divisor.
- Kernels (rows top to bottom):
  - mode 0 gaussian: 1 2 1 / 2 4 2 / 1 2 1
  - mode 1 box: all weights 1
  - mode 2 identity: centre 1, all others 0
  - mode 3 sharpen: 0 −1 0 / −1 5 −1 / 0 −1 0 (only when the configuration macro is defined)
- Arithmetic:
  - Signed accumulator DATA_W+6 bits.
  - Result = acc / (sum of in-bounds weights), truncated toward zero.
  - Result saturates to [0, 2^DATA_W−1].
  - In-bounds weight sum is always >0 for every mode.
- STREAM: outputs samples in the same order as the input.
  - out_data is held stable while out_valid && !out_ready.
  - Advances on out_valid && out_ready.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. mode changes after start has no effect on the current frame.
- in_valid outside LOAD is ignored; no sample is stored.
- reset in any state: immediate return to IDLE with all outputs at reset values. A partial frame is discarded.

## Timing
- start high at edge T (in IDLE): in_ready=1 from T+1.
- Last input accepted at edge L: PROCESS occupies L+1 .. L+WIDTH*HEIGHT.
- out_valid=1 from the cycle after the last PROCESS cycle. First sample is presented combinationally from registered state.
- Back-to-back: with out_ready held high, one sample transfers per cycle.
- Last output transfer at edge E: done=1 during cycle E+1; IDLE, busy=0 from E+2.
- A start asserted during the done cycle is ignored; a new frame may start from E+2.
- Minimum frame time: 2 + 2·WIDTH·HEIGHT·CHANNELS + WIDTH·HEIGHT cycles.

## Configuration
- Macro: IMAGE_CONV_SHARPEN_EN.
- Defined: mode 3 selects the sharpen kernel. The signed accumulate and saturation paths are built.
- Undefined: mode 3 behaves exactly as mode 2 (identity). The accumulator may be unsigned; outputs are bit-identical for modes 0–2.

## Test plan
Use WIDTH=4, HEIGHT=3, CHANNELS=3, DATA_W=8 unless noted.
- Uniform frame, all samples 0x80, mode 0 → all 36 outputs 0x80. Checks border renormalisation. done pulses once.
- Impulse: pixel (1,1) all channels 0xFF, others 0, mode 0 → out(1,1)=0x3F, out(0,0)=0x1C, out(0,3)=0x00.
- Mode 2 with a random frame → output stream identical to input stream. Repeat with in_valid randomly deasserted → still identical.
- out_ready toggled pseudo-randomly, mode 1, ramp frame → no sample dropped, duplicated or changed while stalled. Output count is 36.
- With IMAGE_CONV_SHARPEN_EN, mode 3:
  - Uniform 0x80 → all outputs 0x80.
  - Centre impulse 0xFF → out(1,1)=0xFF (saturated), out(0,1)=0x00 (−127 clamped).
  - Without the macro, the same stimulus → identity output.
- reset asserted mid-LOAD after 10 samples → next cycle in_ready=0, busy=0. A fresh start plus a full frame produces correct output.
